// File: rtl/cnu_minsum_serial.sv
`default_nettype none
// ============================================================================
// Module   : cnu_minsum_serial
// Brief    : Serial min-sum LDPC check-node unit. It collects DEG V2C messages,
//            then streams DEG normalised C2V messages (scale 3/4 or offset).
// Revision : 1.0 - initial release
// ============================================================================
module cnu_minsum_serial #(
    parameter int QW     = 6,
    parameter int DEG    = 8,
    parameter int OFFSET = 1,
    parameter int IW     = $clog2(DEG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          norm_mode,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [QW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [QW-1:0] out_data,
    output logic [IW-1:0] out_idx,
    output logic          out_last
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_EMIT    = 2'd2
    } state_t;

    localparam logic [QW-2:0] c_mag_max = '1;
    localparam logic [QW-2:0] c_off     = (QW-1)'(OFFSET);
    localparam logic [IW-1:0] c_last    = IW'(DEG - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_alive;
    logic            r_mode;
    logic [IW-1:0]   r_cnt;
    logic [QW-2:0]   r_min1;
    logic [QW-2:0]   r_min2;
    logic [IW-1:0]   r_min_idx;
    logic            r_sign_acc;
    logic [DEG-1:0]  r_sign_store;
    logic [QW-1:0]   r_out_data;
    logic [IW-1:0]   r_out_idx;
    logic            r_out_last;

    logic            w_hs_in;
    logic            w_hs_out;
    logic [QW-2:0]   w_mag;
    logic [QW-2:0]   w_min1_n;
    logic [QW-2:0]   w_min2_n;
    logic [IW-1:0]   w_idx_n;
    logic            w_sacc_n;
    logic [DEG-1:0]  w_ss_n;
    logic [IW-1:0]   w_emit_idx;

    // C2V for position j: exclude j's own magnitude and sign, then normalise.
    function automatic logic [QW-1:0] f_c2v(
        input logic [IW-1:0]  j,
        input logic [QW-2:0]  m1,
        input logic [QW-2:0]  m2,
        input logic [IW-1:0]  idx,
        input logic           sacc,
        input logic [DEG-1:0] ss,
        input logic           mode
    );
        logic [QW-2:0] m;
        logic [QW:0]   t3;
        logic [QW-2:0] mag;
        logic          s;
        m   = (j == idx) ? m2 : m1;
        t3  = {2'b00, m} + {1'b0, m, 1'b0};
        if (mode)
            mag = (m > c_off) ? (m - c_off) : '0;
        else
            mag = (QW-1)'(t3 >> 2);
        s = sacc ^ ss[j];
        return s ? (~{1'b0, mag} + QW'(1)) : {1'b0, mag};
    endfunction

    assign w_hs_in    = in_valid & in_ready;
    assign w_hs_out   = out_valid & out_ready;
    assign w_emit_idx = r_out_idx + IW'(1);
    assign in_ready   = r_alive & (r_state != S_EMIT);
    assign out_valid  = (r_state == S_EMIT);
    assign out_data   = r_out_data;
    assign out_idx    = r_out_idx;
    assign out_last   = r_out_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_hs_in) w_state_nxt = S_COLLECT;
            S_COLLECT: if (w_hs_in && (r_cnt == c_last)) w_state_nxt = S_EMIT;
            S_EMIT:    if (w_hs_out && r_out_last) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Running min1/min2 update against the registered values; ties go to min2.
    always_comb begin
        if (in_data[QW-1])
            w_mag = (in_data[QW-2:0] == '0) ? c_mag_max : (~in_data[QW-2:0] + (QW-1)'(1));
        else
            w_mag = in_data[QW-2:0];
        w_min1_n = r_min1;
        w_min2_n = r_min2;
        w_idx_n  = r_min_idx;
        if (w_mag < r_min1) begin
            w_min2_n = r_min1;
            w_min1_n = w_mag;
            w_idx_n  = r_cnt;
        end else if (w_mag < r_min2) begin
            w_min2_n = w_mag;
        end
        w_sacc_n        = r_sign_acc ^ in_data[QW-1];
        w_ss_n          = r_sign_store;
        w_ss_n[r_cnt]   = in_data[QW-1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_alive      <= 1'b0;
            r_mode       <= 1'b0;
            r_cnt        <= '0;
            r_min1       <= c_mag_max;
            r_min2       <= c_mag_max;
            r_min_idx    <= '0;
            r_sign_acc   <= 1'b0;
            r_sign_store <= '0;
            r_out_data   <= '0;
            r_out_idx    <= '0;
            r_out_last   <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            if (w_hs_in) begin
                r_min1       <= w_min1_n;
                r_min2       <= w_min2_n;
                r_min_idx    <= w_idx_n;
                r_sign_acc   <= w_sacc_n;
                r_sign_store <= w_ss_n;
                if (r_cnt == '0)
                    r_mode <= norm_mode;
                if (r_cnt == c_last) begin
                    r_cnt      <= '0;
                    r_out_data <= f_c2v('0, w_min1_n, w_min2_n, w_idx_n, w_sacc_n, w_ss_n, r_mode);
                    r_out_idx  <= '0;
                    r_out_last <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + IW'(1);
                end
            end else if (w_hs_out) begin
                if (r_out_last) begin
                    r_cnt      <= '0;
                    r_min1     <= c_mag_max;
                    r_min2     <= c_mag_max;
                    r_min_idx  <= '0;
                    r_sign_acc <= 1'b0;
                    r_out_data <= '0;
                    r_out_idx  <= '0;
                    r_out_last <= 1'b0;
                end else begin
                    r_out_idx  <= w_emit_idx;
                    r_out_data <= f_c2v(w_emit_idx, r_min1, r_min2, r_min_idx,
                                        r_sign_acc, r_sign_store, r_mode);
                    r_out_last <= (w_emit_idx == c_last);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cnu_minsum_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_cnu_minsum_serial
// Brief    : Self-checking bench: row-level min-sum model plus directed rows.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cnu_minsum_serial;

    localparam int QW  = 6;
    localparam int DEG = 4;

    typedef int row_t [4];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          norm_mode;
    logic [QW-1:0] in_data;
    logic [1:0]    in_valid_v;
    logic [1:0]    out_ready_v;
    logic          in_ready_v  [2];
    logic          out_valid_v [2];
    logic          out_last_v  [2];
    logic [QW-1:0] out_data_v  [2];
    logic [1:0]    out_idx_v   [2];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Min-sum from first principles: each output sees every other input.
    function automatic int model_c2v(input row_t x, input int j, input bit mode, input int off);
        int m = 1000;
        int a;
        int mag;
        bit s = 1'b0;
        for (int i = 0; i < DEG; i++) begin
            if (i != j) begin
                a = (x[i] < 0) ? -x[i] : x[i];
                if (a > 31) a = 31;
                if (a < m) m = a;
                s ^= (x[i] < 0);
            end
        end
        mag = mode ? ((m > off) ? m - off : 0) : (3 * m) / 4;
        return s ? -mag : mag;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        cnu_minsum_serial #(.QW(QW), .DEG(DEG), .OFFSET(g == 0 ? 1 : 5)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .norm_mode (norm_mode),
            .in_valid  (in_valid_v[g]),
            .in_ready  (in_ready_v[g]),
            .in_data   (in_data),
            .out_valid (out_valid_v[g]),
            .out_ready (out_ready_v[g]),
            .out_data  (out_data_v[g]),
            .out_idx   (out_idx_v[g]),
            .out_last  (out_last_v[g])
        );

        int   row_q [$];
        int   exp_q [$];
        bit   row_mode;
        int   oc;
        row_t r;

        always @(negedge clk) begin
            if (!rst) begin
                row_q.delete();
                exp_q.delete();
                oc = 0;
            end else begin
                if (out_valid_v[g]) begin
                    if (exp_q.size() == 0) begin
                        chk($sformatf("dut%0d_spurious_valid", g), int'(out_valid_v[g]), 0);
                    end else begin
                        chk($sformatf("dut%0d_data", g), int'($signed(out_data_v[g])), exp_q[0]);
                        chk($sformatf("dut%0d_idx", g), int'(out_idx_v[g]), oc);
                        chk($sformatf("dut%0d_last", g), int'(out_last_v[g]), int'(oc == DEG - 1));
                        if (out_ready_v[g]) begin
                            void'(exp_q.pop_front());
                            oc = (oc + 1) % DEG;
                        end
                    end
                end
                if (in_valid_v[g] && in_ready_v[g]) begin
                    if (row_q.size() == 0) row_mode = norm_mode;
                    row_q.push_back(int'($signed(in_data)));
                    if (row_q.size() == DEG) begin
                        for (int k = 0; k < DEG; k++) r[k] = row_q[k];
                        for (int j = 0; j < DEG; j++)
                            exp_q.push_back(model_c2v(r, j, row_mode, g == 0 ? 1 : 5));
                        row_q.delete();
                    end
                end
            end
        end
    end

    task automatic send_row(input int d, input row_t v, input int gap, input bit mode);
        norm_mode = mode;
        for (int k = 0; k < DEG; k++) begin
            in_data       = QW'(v[k]);
            in_valid_v[d] = 1'b1;
            chk("in_ready_collect", int'(in_ready_v[d]), 1);
            @(posedge clk); #1;
            if (k == 0) norm_mode = ~mode;
            if (k < DEG - 1) chk("out_valid_early", int'(out_valid_v[d]), 0);
            if (k == 1 && gap > 0) begin
                in_valid_v[d] = 1'b0;
                repeat (gap) begin
                    @(posedge clk); #1;
                    chk("gap_in_ready", int'(in_ready_v[d]), 1);
                end
            end
        end
        in_valid_v[d] = 1'b0;
        chk("latency_valid", int'(out_valid_v[d]), 1);
        chk("latency_idx", int'(out_idx_v[d]), 0);
    endtask

    task automatic wait_idle(input int d);
        int n = 0;
        while ((out_valid_v[d] || !in_ready_v[d]) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_timeout", int'(n < 20), 1);
    endtask

    row_t t_base, t_sat, t_tie, t_clamp, lit;

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        rst         = 1'b0;
        in_valid_v  = 2'b00;
        out_ready_v = 2'b11;
        norm_mode   = 1'b0;
        in_data     = '0;
        t_base  = '{9, -4, 6, 10};
        t_sat   = '{-32, -32, -32, -32};
        t_tie   = '{3, 3, 8, 8};
        t_clamp = '{2, -3, 7, 7};

        lit = '{-3, 4, -3, -3};
        for (int j = 0; j < DEG; j++) chk("model_scale", model_c2v(t_base, j, 1'b0, 1), lit[j]);
        lit = '{-3, 5, -3, -3};
        for (int j = 0; j < DEG; j++) chk("model_offset", model_c2v(t_base, j, 1'b1, 1), lit[j]);
        lit = '{-23, -23, -23, -23};
        for (int j = 0; j < DEG; j++) chk("model_sat", model_c2v(t_sat, j, 1'b0, 1), lit[j]);
        lit = '{2, 2, 2, 2};
        for (int j = 0; j < DEG; j++) chk("model_tie", model_c2v(t_tie, j, 1'b0, 1), lit[j]);
        lit = '{0, 0, 0, 0};
        for (int j = 0; j < DEG; j++) chk("model_clamp", model_c2v(t_clamp, j, 1'b1, 5), lit[j]);

        #12;
        for (int d = 0; d < 2; d++) begin
            chk("rst_in_ready", int'(in_ready_v[d]), 0);
            chk("rst_out_valid", int'(out_valid_v[d]), 0);
            chk("rst_out_data", int'(out_data_v[d]), 0);
            chk("rst_out_idx", int'(out_idx_v[d]), 0);
            chk("rst_out_last", int'(out_last_v[d]), 0);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) chk("post_rst_in_ready", int'(in_ready_v[d]), 1);

        send_row(0, t_base, 0, 1'b0);  wait_idle(0);
        send_row(0, t_base, 0, 1'b1);  wait_idle(0);
        send_row(0, t_sat,  0, 1'b0);  wait_idle(0);
        send_row(0, t_tie,  2, 1'b0);  wait_idle(0);

        // Backpressure at idx1 of a scale-mode row.
        out_ready_v[0] = 1'b0;
        send_row(0, t_base, 0, 1'b0);
        out_ready_v[0] = 1'b1;
        @(posedge clk); #1;
        out_ready_v[0] = 1'b0;
        chk("bp_idx", int'(out_idx_v[0]), 1);
        repeat (3) begin
            @(posedge clk); #1;
            chk("bp_hold_idx", int'(out_idx_v[0]), 1);
            chk("bp_hold_data", int'($signed(out_data_v[0])), 4);
            chk("bp_hold_valid", int'(out_valid_v[0]), 1);
            chk("bp_in_ready", int'(in_ready_v[0]), 0);
        end
        out_ready_v[0] = 1'b1;
        @(posedge clk); #1;
        chk("bp_idx2", int'(out_idx_v[0]), 2);
        @(posedge clk); #1;
        chk("bp_idx3", int'(out_idx_v[0]), 3);
        chk("bp_last", int'(out_last_v[0]), 1);
        @(posedge clk); #1;
        chk("end_out_valid", int'(out_valid_v[0]), 0);
        chk("end_in_ready", int'(in_ready_v[0]), 1);
        send_row(0, t_clamp, 0, 1'b1); wait_idle(0);

        // Offset clamp on the OFFSET=5 instance, then abort mid-EMIT.
        out_ready_v[1] = 1'b0;
        send_row(1, t_clamp, 0, 1'b1);
        @(posedge clk); #1;
        chk("clamp_stall_valid", int'(out_valid_v[1]), 1);
        chk("clamp_stall_data", int'($signed(out_data_v[1])), 0);
        rst = 1'b0;
        #1;
        chk("abort_out_valid", int'(out_valid_v[1]), 0);
        chk("abort_in_ready", int'(in_ready_v[1]), 0);
        chk("abort_out_idx", int'(out_idx_v[1]), 0);
        chk("abort_out_last", int'(out_last_v[1]), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        out_ready_v[1] = 1'b1;
        @(posedge clk); #1;
        chk("abort_recover_ready", int'(in_ready_v[1]), 1);
        send_row(1, t_base, 0, 1'b0); wait_idle(1);

        chk("leftover_dut0", g_dut[0].exp_q.size(), 0);
        chk("leftover_dut1", g_dut[1].exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
